mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Parametrised, fully registered memory-stage controller between the EX/MEM pipeline register and the data cache. It replaces the combinational done/latch handshake of the previous memory stage with a valid/ready FSM, and adds width generalisation, misalignment detection, load sign/zero extension, and a cache-clean (ecall) request path. One request is in flight at a time; snoop stalls from the cache block new acceptance.

## Interface
- XLEN, 64: data width, 32 or 64.
- AW, 64: address width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request from EX/MEM.
- in_ready  out  1  stage can accept.
- in_read / in_write / in_clean  in  1 each  load / store / cache-clean request; at most one set.
- in_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- in_unsigned  in  1  zero-extend load.
- in_addr  in  AW  effective address (ALU result).
- in_wdata  in  XLEN  store data, LSB-aligned.
- snoop_stall  in  1  cache servicing a snoop.
- dc_read_en / dc_write_en / dc_clean_en  out  1 each  level requests to the cache, held until done.
- dc_addr  out  AW  registered request address.
- dc_size  out  2  registered size.
- dc_wdata  out  XLEN  registered store data.
- dc_done  in  1  one-cycle completion pulse for a read or write.
- dc_rdata  in  XLEN  LSB-aligned load data, valid with dc_done.
- dc_clean_done  in  1  clean completion pulse.
- out_valid  out  1  result for MEM/WB.
- out_ready  in  1  MEM/WB latched the result.
- out_data  out  XLEN  extended load data; 0 for non-loads.
- out_misaligned  out  1  request faulted; no cache access was made.

## Operation
- States: IDLE, ACCESS, CLEAN, HOLD.
- in_ready = (state==IDLE) && !snoop_stall. A request is accepted when in_valid && in_ready.
- On acceptance in IDLE, the controller registers addr, size, wdata, unsigned and op, then:
  - Misaligned (addr mod 2^size ≠ 0 on a read/write) or illegal (size==3 with XLEN==32) → HOLD with out_misaligned=1 and out_data=0. No dc_* enable is raised.
  - read or write → ACCESS.
  - clean → CLEAN.
  - none of these (ALU-only op) → HOLD with out_data=0.
- ACCESS: dc_read_en or dc_write_en is asserted from the registered op. On dc_done, loads capture ext(dc_rdata) and stores capture 0, then → HOLD. Enables drop in the HOLD cycle.
- CLEAN: dc_clean_en is asserted. On dc_clean_done → HOLD with out_data=0.
- HOLD: out_valid=1 and the result stays stable. out_ready → IDLE.
- Extension: load data is truncated to 8/16/32/64 bits, then sign- or zero-extended to XLEN per in_unsigned.
- dc_done or dc_clean_done arriving outside its matching state is ignored.
- snoop_stall only gates acceptance. It never aborts ACCESS or CLEAN.

## Timing
- All outputs are registered except in_ready, which is combinational from state and snoop_stall.
- Reset values: state=IDLE, all dc_*_en=0, dc_addr=0, dc_size=0, dc_wdata=0, out_valid=0, out_data=0, out_misaligned=0.
- Latency, hit with dc_done one cycle after ACCESS entry: accept at cycle 0, ACCESS at cycles 1–2, out_valid at cycle 3. In general, out_valid rises the cycle after dc_done.
- Misaligned or ALU-only request: out_valid rises the cycle after acceptance.
- Back-to-back: if out_ready is seen in HOLD at cycle n, in_ready can be 1 at n+1. There is no same-cycle turnaround.
- Reset mid-ACCESS or mid-CLEAN: enables deassert and state returns to IDLE at the next edge. Any late dc_done is then ignored.

## Structure
- mem_stage_pkg holds the state enum, the size encoding constants, and an op enum (NONE/READ/WRITE/CLEAN).
- Sub-module mem_load_extend: purely combinational (size, unsigned, raw) → extended XLEN data. It is reused by the writeback forwarding logic.

## Test plan
- Load byte 0x80 from addr 0x1003, signed → dc_read_en held until dc_done; out_data=0xFFFF_FFFF_FFFF_FF80 with out_valid the next cycle.
- Load half from addr 0x1001 → out_misaligned=1, dc_read_en never asserted, out_valid one cycle after acceptance.
- Store dword 0xDEADBEEF_CAFEF00D to 0x2000, out_ready held low for 5 cycles → out_valid stays 1 with out_data=0 and in_ready=0 throughout, then IDLE.
- snoop_stall=1 while in_valid=1 → in_ready=0 and no acceptance; the request is accepted on the first cycle snoop_stall=0.
- Clean request → dc_clean_en until dc_clean_done, then out_valid. A stray dc_done during CLEAN is ignored.
- Reset asserted in ACCESS → all outputs at reset values the next cycle; a following dc_done produces no out_valid.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_pkg: shared state, op and access-size encodings for the memory stage
package mem_stage_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, CLEAN, HOLD} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE, OP_CLEAN} op_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: data-cache request/response bus between the memory stage and the cache
interface mem_stage_ctrl_if #(parameter int XLEN = 64, parameter int AW = 64);
  logic            read_en;
  logic            write_en;
  logic            clean_en;
  logic [AW-1:0]   addr;
  logic [1:0]      size;
  logic [XLEN-1:0] wdata;
  logic            done;
  logic [XLEN-1:0] rdata;
  logic            clean_done;
  logic            snoop_stall;
  modport master(output read_en, write_en, clean_en, addr, size, wdata, input done, rdata, clean_done, snoop_stall);
  modport slave(input read_en, write_en, clean_en, addr, size, wdata, output done, rdata, clean_done, snoop_stall);
endinterface

// File: rtl/mem_load_extend.sv
// mem_load_extend: truncates LSB-aligned load data to the access size and sign/zero-extends it
module mem_load_extend import mem_stage_pkg::*; #(parameter int XLEN = 64) (
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext
);
  logic [6:0] w, sh;
  logic [XLEN-1:0] t;
  logic signed [XLEN-1:0] s;
  // shift the field to the top, then shift back arithmetically or logically
  always_comb begin
    w = size == SZ_B ? 7'd8 : size == SZ_H ? 7'd16 : size == SZ_W ? 7'd32 : 7'd64;
    sh = w >= 7'(XLEN) ? 7'd0 : 7'(XLEN) - w;
    t = raw << sh;
    s = $signed(t) >>> sh;
    ext = uns ? t >> sh : s;
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: registered valid/ready memory-stage controller driving the data cache
module mem_stage_ctrl import mem_stage_pkg::*; #(parameter int XLEN = 64, parameter int AW = 64) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_read,
  input  logic            in_write,
  input  logic            in_clean,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [AW-1:0]   in_addr,
  input  logic [XLEN-1:0] in_wdata,
  mem_stage_ctrl_if.master dc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_misaligned
);
  state_t state, state_n;
  op_t op, op_n, req_op;
  logic uns, accept, mis, mis_n, rd_n, wr_n, cl_n;
  logic [AW-1:0] mask;
  logic [XLEN-1:0] ext, data_n;
  assign in_ready = state == IDLE && !dc.snoop_stall;
  assign accept = in_valid && in_ready;
  assign req_op = in_read ? OP_READ : in_write ? OP_WRITE : in_clean ? OP_CLEAN : OP_NONE;
  assign mask = AW'((4'd1 << in_size) - 4'd1);
  assign mis = (req_op == OP_READ || req_op == OP_WRITE) &&
               ((in_addr & mask) != '0 || (in_size == SZ_D && XLEN == 32));
  mem_load_extend #(.XLEN(XLEN)) u_ext (
    .size(dc.size),
    .uns (uns),
    .raw (dc.rdata),
    .ext (ext)
  );
  always_comb begin
    state_n = state;
    op_n = op;
    data_n = out_data;
    mis_n = out_misaligned;
    case (state)
      IDLE: if (accept) begin
        op_n = req_op;
        data_n = '0;
        mis_n = mis;
        state_n = (mis || req_op == OP_NONE) ? HOLD : req_op == OP_CLEAN ? CLEAN : ACCESS;
      end
      ACCESS: if (dc.done) begin
        state_n = HOLD;
        data_n = op == OP_READ ? ext : '0;
      end
      CLEAN: if (dc.clean_done) begin
        state_n = HOLD;
        data_n = '0;
      end
      HOLD: if (out_ready) begin
        state_n = IDLE;
        data_n = '0;
        mis_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    rd_n = state_n == ACCESS && op_n == OP_READ;
    wr_n = state_n == ACCESS && op_n == OP_WRITE;
    cl_n = state_n == CLEAN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op <= OP_NONE;
      uns <= 1'b0;
      dc.read_en <= 1'b0;
      dc.write_en <= 1'b0;
      dc.clean_en <= 1'b0;
      dc.addr <= '0;
      dc.size <= '0;
      dc.wdata <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_misaligned <= 1'b0;
    end else begin
      state <= state_n;
      op <= op_n;
      dc.read_en <= rd_n;
      dc.write_en <= wr_n;
      dc.clean_en <= cl_n;
      out_valid <= state_n == HOLD;
      out_data <= data_n;
      out_misaligned <= mis_n;
      if (accept) begin
        uns <= in_unsigned;
        dc.addr <= in_addr;
        dc.size <= in_size;
        dc.wdata <= in_wdata;
      end
    end
  end
endmodule
